// File: rtl/mem_access_stage.sv
// Memory-access stage: request/grant/response data-memory transaction with load extension and timeout.
// Optional misalignment trap enabled by defining MEM_ACCESS_STAGE_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RD2,
  input  logic [2:0]  funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [31:0] r_out_data, w_out_data_nxt;
  logic        r_bus_err, w_bus_err_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic        r_dmem_req, w_req_nxt;
  logic        r_dmem_we, w_we_nxt;
  logic [31:0] r_dmem_addr, w_daddr_nxt;
  logic [31:0] r_dmem_wdata, w_wdata_nxt;
  logic [3:0]  r_dmem_be, w_be_nxt;

  logic        w_load_f3_ok, w_store_f3_ok, w_illegal, w_misal;
  logic [16:0] w_tmo_inc;
  logic        w_tmo_hit;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  assign in_ready   = (r_state == S_IDLE) & ~rst;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign dmem_be    = r_dmem_be;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign bus_err    = r_bus_err;
  assign misalign   = r_misalign;

  assign w_load_f3_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_store_f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
  assign w_illegal     = (MemRead & MemWrite) | (MemRead & ~w_load_f3_ok) |
                         (MemWrite & ~w_store_f3_ok);

`ifdef MEM_ACCESS_STAGE_MISALIGN_TRAP_EN
  assign w_misal = ((funct3[1:0] == 2'b01) & ALUResult[0]) |
                   ((funct3[1:0] == 2'b10) & (|ALUResult[1:0]));
`else
  assign w_misal = 1'b0;
`endif

  // The budget spans REQ and WAIT_R together; it is only cleared on entering REQ.
  assign w_tmo_inc = {1'b0, r_tmo_cnt} + 17'd1;
  assign w_tmo_hit = (w_tmo_inc >= 17'(TIMEOUT_CYCLES));

  always_comb begin
    // NOTE: every combinational target gets a default first so no latch is inferred.
    w_st_be    = 4'b1111;
    w_st_wdata = RD2;
    unique case (funct3[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << ALUResult[1:0];
        w_st_wdata = {4{RD2[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << {ALUResult[1], 1'b0};
        w_st_wdata = {2{RD2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ld_byte = dmem_rdata[7:0];
    unique case (r_addr[1:0])
      2'b01:   w_ld_byte = dmem_rdata[15:8];
      2'b10:   w_ld_byte = dmem_rdata[23:16];
      2'b11:   w_ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    w_ld_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_addr_nxt      = r_addr;
    w_funct3_nxt    = r_funct3;
    w_out_valid_nxt = 1'b0;
    w_out_data_nxt  = r_out_data;
    w_bus_err_nxt   = r_bus_err;
    w_misalign_nxt  = r_misalign;
    w_req_nxt       = r_dmem_req;
    w_we_nxt        = r_dmem_we;
    w_daddr_nxt     = r_dmem_addr;
    w_wdata_nxt     = r_dmem_wdata;
    w_be_nxt        = r_dmem_be;

    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_addr_nxt     = ALUResult;
          w_funct3_nxt   = funct3;
          w_bus_err_nxt  = 1'b0;
          w_misalign_nxt = 1'b0;
          if (!MemRead && !MemWrite) begin
            w_state_nxt     = S_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = ALUResult;
          end else if (w_illegal) begin
            w_state_nxt     = S_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = 32'd0;
            w_bus_err_nxt   = 1'b1;
          end else if (w_misal) begin
            w_state_nxt     = S_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = 32'd0;
            w_misalign_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_REQ;
            w_tmo_cnt_nxt = 16'd0;
            w_req_nxt     = 1'b1;
            w_we_nxt      = MemWrite;
            w_daddr_nxt   = {ALUResult[31:2], 2'b00};
            w_be_nxt      = MemWrite ? w_st_be : 4'b1111;
            w_wdata_nxt   = MemWrite ? w_st_wdata : 32'd0;
          end
        end
      end

      S_REQ: begin
        w_tmo_cnt_nxt = w_tmo_inc[15:0];
        if (dmem_gnt) begin
          w_req_nxt = 1'b0;
          if (r_dmem_we) begin
            w_state_nxt     = S_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = r_addr;
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end else if (w_tmo_hit) begin
          w_req_nxt       = 1'b0;
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = 32'd0;
          w_bus_err_nxt   = 1'b1;
        end
      end

      S_WAIT_R: begin
        w_tmo_cnt_nxt = w_tmo_inc[15:0];
        if (dmem_rvalid) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_ld_data;
        end else if (w_tmo_hit) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = 32'd0;
          w_bus_err_nxt   = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt    = S_IDLE;
        w_bus_err_nxt  = 1'b0;
        w_misalign_nxt = 1'b0;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tmo_cnt    <= 16'd0;
      r_addr       <= 32'd0;
      r_funct3     <= 3'd0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 32'd0;
      r_bus_err    <= 1'b0;
      r_misalign   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_be    <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_funct3     <= w_funct3_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_bus_err    <= w_bus_err_nxt;
      r_misalign   <= w_misalign_nxt;
      r_dmem_req   <= w_req_nxt;
      r_dmem_we    <= w_we_nxt;
      r_dmem_addr  <= w_daddr_nxt;
      r_dmem_wdata <= w_wdata_nxt;
      r_dmem_be    <= w_be_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (TIMEOUT_CYCLES = 4) plus timeout and reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUResult, RD2;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        bus_err, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .RD2(RD2), .funct3(funct3),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_data(out_data),
    .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [2:0]  f3;
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int          gnt_dly;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic mr, input logic mw,
                       input logic [31:0] addr, input logic [31:0] rd2);
    funct3 = f3; MemRead = mr; MemWrite = mw; ALUResult = addr; RD2 = rd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    string t;
    int    req_hi;
    t = $sformatf("v%0d", v.id);
    check({t, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    drive(v.f3, v.mr, v.mw, v.addr, v.rd2);
    if (v.exp_req) begin
      check({t, ".addr"}, dmem_addr, v.exp_addr);
      check({t, ".be"}, 32'(dmem_be), 32'(v.exp_be));
      check({t, ".we"}, 32'(dmem_we), 32'(v.mw));
      if (v.mw) check({t, ".wdata"}, dmem_wdata, v.exp_wdata);
      req_hi = 0;
      for (int d = 0; d < v.gnt_dly; d++) begin
        req_hi += int'(dmem_req);
        @(posedge clk); #1;
      end
      req_hi += int'(dmem_req);
      dmem_gnt = 1'b1;
      // Junk read data during the grant cycle must be ignored.
      dmem_rvalid = v.mr; dmem_rdata = 32'h0BAD0BAD;
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      check({t, ".req_cycles"}, 32'(req_hi), 32'(v.gnt_dly + 1));
      check({t, ".req_dropped"}, 32'(dmem_req), 32'd0);
      if (v.mr) begin
        check({t, ".early_valid"}, 32'(out_valid), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      end
    end else begin
      check({t, ".no_req"}, 32'(dmem_req), 32'd0);
    end
    check({t, ".out_valid"}, 32'(out_valid), 32'd1);
    check({t, ".in_ready_done"}, 32'(in_ready), 32'd0);
    check({t, ".bus_err"}, 32'(bus_err), 32'(v.exp_err));
    check({t, ".misalign"}, 32'(misalign), 32'(v.exp_mis));
    if (v.chk_data) check({t, ".out_data"}, out_data, v.exp_data);
    @(posedge clk); #1;
    check({t, ".pulse_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int req_hi;
    //          id f3     mr mw addr          rd2           rdata         dly req exp_addr      be       wdata         chk data          err mis
    vecs[0]  = '{0,  3'b010, 1, 0, 32'h00000104, 32'h0,        32'hDEADBEEF, 0, 1, 32'h00000104, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{1,  3'b000, 1, 0, 32'h00000103, 32'h0,        32'h80FF1234, 0, 1, 32'h00000100, 4'b1111, 32'h0,        1, 32'hFFFFFF80, 0, 0};
    vecs[2]  = '{2,  3'b100, 1, 0, 32'h00000103, 32'h0,        32'h80FF1234, 1, 1, 32'h00000100, 4'b1111, 32'h0,        1, 32'h00000080, 0, 0};
    vecs[3]  = '{3,  3'b101, 1, 0, 32'h00000102, 32'h0,        32'h80FF1234, 0, 1, 32'h00000100, 4'b1111, 32'h0,        1, 32'h000080FF, 0, 0};
    vecs[4]  = '{4,  3'b001, 1, 0, 32'h00000102, 32'h0,        32'h80FF1234, 0, 1, 32'h00000100, 4'b1111, 32'h0,        1, 32'hFFFF80FF, 0, 0};
    vecs[5]  = '{5,  3'b000, 1, 0, 32'h00000100, 32'h0,        32'h80FF1234, 0, 1, 32'h00000100, 4'b1111, 32'h0,        1, 32'h00000034, 0, 0};
    vecs[6]  = '{6,  3'b000, 0, 1, 32'h00000201, 32'h000000A5, 32'h0,        3, 1, 32'h00000200, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0, 0};
    vecs[7]  = '{7,  3'b001, 0, 1, 32'h00000202, 32'h1234BEEF, 32'h0,        0, 1, 32'h00000200, 4'b1100, 32'hBEEFBEEF, 0, 32'h0,        0, 0};
    vecs[8]  = '{8,  3'b010, 0, 1, 32'h00000300, 32'hCAFEF00D, 32'h0,        1, 1, 32'h00000300, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0, 0};
    vecs[9]  = '{9,  3'b000, 0, 0, 32'h0000002A, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h0000002A, 0, 0};
    vecs[10] = '{10, 3'b010, 1, 1, 32'h00000100, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000000, 1, 0};
    vecs[11] = '{11, 3'b011, 1, 0, 32'h00000100, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000000, 1, 0};
    vecs[12] = '{12, 3'b100, 0, 1, 32'h00000100, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000000, 1, 0};
`ifdef MEM_ACCESS_STAGE_MISALIGN_TRAP_EN
    vecs[13] = '{13, 3'b010, 0, 1, 32'h00000102, 32'h11223344, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000000, 0, 1};
    vecs[14] = '{14, 3'b001, 1, 0, 32'h00000103, 32'h0,        32'h80FF1234, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000000, 0, 1};
    vecs[15] = '{15, 3'b001, 0, 1, 32'h00000203, 32'h00007F01, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000000, 0, 1};
`else
    vecs[13] = '{13, 3'b010, 0, 1, 32'h00000102, 32'h11223344, 32'h0,        0, 1, 32'h00000100, 4'b1111, 32'h11223344, 0, 32'h0,        0, 0};
    vecs[14] = '{14, 3'b001, 1, 0, 32'h00000103, 32'h0,        32'h80FF1234, 0, 1, 32'h00000100, 4'b1111, 32'h0,        1, 32'hFFFF80FF, 0, 0};
    vecs[15] = '{15, 3'b001, 0, 1, 32'h00000203, 32'h00007F01, 32'h0,        0, 1, 32'h00000200, 4'b1100, 32'h7F017F01, 0, 32'h0,        0, 0};
`endif

    rst = 1'b1; in_valid = 1'b0; ALUResult = '0; RD2 = '0; funct3 = '0;
    MemRead = 1'b0; MemWrite = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", out_data, 32'd0);
    check("rst.dmem_req", 32'(dmem_req), 32'd0);
    check("rst.dmem_be", 32'(dmem_be), 32'd0);
    check("rst.dmem_addr", dmem_addr, 32'd0);
    check("rst.flags", 32'({bus_err, misalign, dmem_we}), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) do_op(vecs[i]);

    // Load with no grant: request held four cycles, then bus error.
    drive(3'b010, 1'b1, 1'b0, 32'h00000400, 32'h0);
    req_hi = 0;
    for (int c = 0; c < 4; c++) begin
      req_hi += int'(dmem_req);
      @(posedge clk); #1;
    end
    check("tmo_req.req_cycles", 32'(req_hi), 32'd4);
    check("tmo_req.out_valid", 32'(out_valid), 32'd1);
    check("tmo_req.bus_err", 32'(bus_err), 32'd1);
    check("tmo_req.out_data", out_data, 32'd0);
    check("tmo_req.req_dropped", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    check("tmo_req.pulse_end", 32'(out_valid), 32'd0);

    // Grant on first cycle, no read data: budget continues through WAIT_R.
    drive(3'b010, 1'b1, 1'b0, 32'h00000404, 32'h0);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("tmo_rd.wait%0d", c), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("tmo_rd.wait2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("tmo_rd.out_valid", 32'(out_valid), 32'd1);
    check("tmo_rd.bus_err", 32'(bus_err), 32'd1);
    check("tmo_rd.out_data", out_data, 32'd0);
    @(posedge clk); #1;
    check("tmo_rd.in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of REQ abandons the access; late bus responses are ignored.
    drive(3'b010, 1'b1, 1'b0, 32'h00000500, 32'h0);
    check("rst_mid.req_high", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid.in_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid.req_low", 32'(dmem_req), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_mid.late%0d_valid", c), 32'(out_valid), 32'd0);
      check($sformatf("rst_mid.late%0d_req", c), 32'(dmem_req), 32'd0);
      check($sformatf("rst_mid.late%0d_ready", c), 32'(in_ready), 32'd1);
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;

    do_op(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
